// File: rtl/strategy_switch_ctrl.sv
// Writer side of the strategy_mux select/parameter interface: accepts change requests and
// performs a drain -> guard -> commit changeover so strategy_sel/par never move while outputs are live.
package strategy_switch_pkg;
    typedef logic [2:0] parameters_t;
endpackage

module strategy_switch_ctrl
    import strategy_switch_pkg::*;
#(
    parameter int          NUM_STRATEGIES   = 5,
    parameter logic [7:0]  DEFAULT_STRATEGY = 8'd0,
    parameter parameters_t DEFAULT_PAR      = 3'b001,
    parameter int          GUARD_CYCLES     = 16,
    parameter int          DRAIN_TIMEOUT    = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_strategy,
    input  parameters_t req_par,
    input  logic        busy_in,
    output logic [7:0]  strategy_sel,
    output parameters_t par,
    output logic        out_enable,
    output logic        switch_done,
    output logic        err_invalid,
    output logic        err_timeout,
    output logic [15:0] switch_count
);

    localparam int CNT_MAX = (GUARD_CYCLES > DRAIN_TIMEOUT) ? GUARD_CYCLES : DRAIN_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [8:0]    NUM_CODES  = 9'(NUM_STRATEGIES);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_DRAIN,
        ST_GUARD,
        ST_COMMIT
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [7:0]  lat_strategy;
    parameters_t lat_par;

    logic req_in_range;
    logic req_is_current;
    assign req_in_range   = ({1'b0, req_strategy} < NUM_CODES);
    assign req_is_current = (req_strategy == strategy_sel) && (req_par == par);

    // NOTE: every register here, including the latched request, is updated with <= so all
    // next-state decisions see the values from before the edge; the latch is reset too so a
    // stale request can never be committed after a mid-operation reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_STARTUP;
            cnt          <= '0;
            lat_strategy <= DEFAULT_STRATEGY;
            lat_par      <= DEFAULT_PAR;
            strategy_sel <= DEFAULT_STRATEGY;
            par          <= DEFAULT_PAR;
            out_enable   <= 1'b0;
            req_ready    <= 1'b0;
            switch_done  <= 1'b0;
            err_invalid  <= 1'b0;
            err_timeout  <= 1'b0;
            switch_count <= '0;
        end else begin
            switch_done <= 1'b0;
            err_invalid <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                ST_STARTUP: begin
                    if (cnt == GUARD_LAST) begin
                        state      <= ST_IDLE;
                        out_enable <= 1'b1;
                        req_ready  <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_strategy <= req_strategy;
                        lat_par      <= req_par;
                        if (!req_in_range) begin
                            err_invalid <= 1'b1;
                        end else if (req_is_current) begin
                            switch_done <= 1'b1;
                        end else begin
                            state     <= ST_DRAIN;
                            req_ready <= 1'b0;
                            cnt       <= '0;
                        end
                    end
                end

                // Outputs stay live while the running strategy finishes its sequence.
                ST_DRAIN: begin
                    if (!busy_in || cnt == DRAIN_LAST) begin
                        err_timeout <= busy_in;
                        state       <= ST_GUARD;
                        out_enable  <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        state        <= ST_COMMIT;
                        strategy_sel <= lat_strategy;
                        par          <= lat_par;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_COMMIT: begin
                    state       <= ST_IDLE;
                    out_enable  <= 1'b1;
                    req_ready   <= 1'b1;
                    switch_done <= 1'b1;
                    if (switch_count != 16'hFFFF) begin
                        switch_count <= switch_count + 16'd1;
                    end
                end

                default: begin
                    state <= ST_STARTUP;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_strategy_switch_ctrl.sv
// Self-checking bench for strategy_switch_ctrl: directed scenarios plus randomized requests
// checked cycle by cycle against a transaction-level timeline model.
module tb_strategy_switch_ctrl;
    import strategy_switch_pkg::*;

    localparam int G  = 16;
    localparam int DT = 256;
    localparam int NS = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_strategy = 8'd0;
    parameters_t req_par = 3'd0;
    logic        busy_in = 1'b0;
    logic [7:0]  strategy_sel;
    parameters_t par;
    logic        out_enable;
    logic        switch_done;
    logic        err_invalid;
    logic        err_timeout;
    logic [15:0] switch_count;

    strategy_switch_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_strategy (req_strategy),
        .req_par      (req_par),
        .busy_in      (busy_in),
        .strategy_sel (strategy_sel),
        .par          (par),
        .out_enable   (out_enable),
        .switch_done  (switch_done),
        .err_invalid  (err_invalid),
        .err_timeout  (err_timeout),
        .switch_count (switch_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the controller should currently be presenting.
    logic [7:0]  m_sel;
    parameters_t m_par;
    int          m_count;

    function automatic logic [31:0] observed();
        return {out_enable, req_ready, switch_done, err_invalid, err_timeout,
                strategy_sel, par, switch_count};
    endfunction

    task automatic model_reset();
        m_sel   = 8'd0;
        m_par   = 3'b001;
        m_count = 0;
    endtask

    // Release reset mid-cycle and expect exactly G edges of disabled outputs before IDLE.
    task automatic test_startup(input string name);
        int n;
        logic [31:0] exp_v;
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        while (out_enable !== 1'b1 && n < 64) begin
            @(posedge clock);
            #1;
            n++;
        end
        n_cmp++;
        if (n != G) begin
            n_err++;
            $display("FAIL %s startup_len: got %0d edges want %0d", name, n, G);
        end
        exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'b001, 16'd0};
        n_cmp++;
        if (observed() !== exp_v) begin
            n_err++;
            $display("FAIL %s idle_defaults: got %h want %h", name, observed(), exp_v);
        end
    endtask

    task automatic test_reset();
        logic [31:0] exp_v;
        model_reset();
        reset = 1'b0;
        #12;
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b001, 16'd0};
        n_cmp++;
        if (observed() !== exp_v) begin
            n_err++;
            $display("FAIL reset_values: got %h want %h", observed(), exp_v);
        end
        test_startup("reset");
    endtask

    // Issue one request from IDLE and check every cycle until the controller is idle again.
    // b = number of DRAIN edges that still see busy_in high; inject = poke req_valid during DRAIN.
    task automatic do_request(input logic [7:0] s, input parameters_t p, input int b,
                              input bit inject, input string name);
        logic [31:0] exp_v;
        int          d_rel;
        int          last;
        bit          tmo;
        int          next_count;

        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, req_ready);
        end
        req_strategy = s;
        req_par      = p;
        req_valid    = 1'b1;
        busy_in      = (b > 0);
        @(posedge clock);
        #1;
        req_valid = 1'b0;

        if (s >= NS || (s == m_sel && p == m_par)) begin
            exp_v = {1'b1, 1'b1, (s < NS), (s >= NS), 1'b0, m_sel, m_par, 16'(m_count)};
            n_cmp++;
            if (observed() !== exp_v) begin
                n_err++;
                $display("FAIL %s immediate_resp: got %h want %h", name, observed(), exp_v);
            end
            @(posedge clock);
            #1;
            exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m_sel, m_par, 16'(m_count)};
            n_cmp++;
            if (observed() !== exp_v) begin
                n_err++;
                $display("FAIL %s pulse_clear: got %h want %h", name, observed(), exp_v);
            end
        end else begin
            tmo        = (b >= DT);
            d_rel      = 1 + (tmo ? DT - 1 : b);
            last       = d_rel + G + 1;
            next_count = (m_count < 65535) ? m_count + 1 : 65535;
            for (int e = 1; e <= last; e++) begin
                busy_in      = (e <= b);
                req_valid    = inject && (e == 2) && (d_rel > 2);
                req_strategy = s ^ 8'h01;
                @(posedge clock);
                #1;
                req_valid = 1'b0;
                exp_v = {(e < d_rel) || (e == last),
                         (e == last),
                         (e == last),
                         1'b0,
                         tmo && (e == d_rel),
                         (e >= d_rel + G) ? s : m_sel,
                         (e >= d_rel + G) ? p : m_par,
                         16'((e == last) ? next_count : m_count)};
                n_cmp++;
                if (observed() !== exp_v) begin
                    n_err++;
                    $display("FAIL %s cycle_%0d: got %h want %h", name, e, observed(), exp_v);
                end
            end
            m_sel   = s;
            m_par   = p;
            m_count = next_count;
        end
        busy_in = 1'b0;
    endtask

    task automatic test_switch();
        do_request(8'd3, 3'b010, 0, 1'b0, "switch_3");
    endtask

    task automatic test_invalid();
        do_request(8'd7, 3'b110, 0, 1'b0, "invalid_7");
        do_request(8'd5, 3'b000, 0, 1'b0, "invalid_5");
    endtask

    task automatic test_timeout();
        do_request(8'd2, 3'b011, 300, 1'b0, "timeout");
    endtask

    task automatic test_busy_drop();
        do_request(8'd4, 3'b101, 40, 1'b0, "busy_drop");
        do_request(8'd4, 3'b101, 0, 1'b0, "same_value");
        do_request(8'd4, 3'b100, 255, 1'b0, "drop_at_limit");
    endtask

    task automatic test_ignore_in_drain();
        do_request(8'd1, 3'b011, 10, 1'b1, "ignore_in_drain");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  s;
        parameters_t p;
        for (int i = 0; i < 12; i++) begin
            s = 8'($urandom_range(0, 7));
            p = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                s = m_sel;
                p = m_par;
            end
            do_request(s, p, $urandom_range(0, 12), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_in_guard();
        logic [31:0] exp_v;
        req_strategy = (m_sel == 8'd4) ? 8'd3 : 8'd4;
        req_par      = 3'b111;
        req_valid    = 1'b1;
        busy_in      = 1'b0;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (6) begin
            @(posedge clock);
            #1;
        end
        n_cmp++;
        if (out_enable !== 1'b0) begin
            n_err++;
            $display("FAIL guard_reached: got out_enable %b want 0", out_enable);
        end
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b001, 16'd0};
        n_cmp++;
        if (observed() !== exp_v) begin
            n_err++;
            $display("FAIL reset_in_guard: got %h want %h", observed(), exp_v);
        end
        test_startup("restart");
        do_request(8'd3, 3'b010, 0, 1'b0, "after_restart");
    endtask

    initial begin
        test_reset();
        test_switch();
        test_invalid();
        test_timeout();
        test_busy_drop();
        test_ignore_in_drain();
        test_back_to_back();
        test_reset_in_guard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
